// File: rtl/cache_control_nway_if.sv
// CPU/datapath-side handshake and array-control bundle for the N-way cache controller.
// master = CPU request + datapath status + pmem completion; slave = controller.
interface cache_control_nway_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int IDXW = $clog2(SETS);
    localparam int WAYW = $clog2(WAYS);

    logic            mem_read;
    logic            mem_write;
    logic            mem_resp;
    logic [IDXW-1:0] set_idx;
    logic [WAYS-1:0] hit_vec;
    logic [WAYS-1:0] valid_vec;
    logic [WAYS-1:0] dirty_vec;
    logic [WAYS-1:0] load_data;
    logic [WAYS-1:0] load_tag;
    logic [WAYS-1:0] load_valid;
    logic [WAYS-1:0] load_dirty;
    logic            dirty_in;
    logic            datain_sel;
    logic            pmem_addr_sel;
    logic [WAYW-1:0] victim_way;
    logic            pmem_read;
    logic            pmem_write;
    logic            pmem_resp;

    modport master (
        output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
        input  mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
               datain_sel, pmem_addr_sel, victim_way, pmem_read, pmem_write
    );

    modport slave (
        input  mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
        output mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
               datain_sel, pmem_addr_sel, victim_way, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_control_nway.sv
// Controller FSM for a WAYS-way write-back, write-allocate cache with per-set tree PLRU.
// Latency: hit -> mem_resp one cycle after the request; a miss adds the WB and FILL pmem handshakes.
// Backpressure: CPU holds its request until mem_resp; WB and FILL hold until pmem_resp.
module cache_control_nway #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                clk,
    input  logic                rst,
    cache_control_nway_if.slave bus
);
    localparam int WAYW = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, HIT, WB, FILL} state_t;

    state_t          state;
    logic [WAYS-1:0] plru [SETS];
    logic [WAYW-1:0] victim_q;
    logic [WAYW-1:0] hit_way;
    logic            hit_write;
    logic [WAYW-1:0] hit_sel;
    logic [WAYW-1:0] miss_sel;
    logic            fill_done;
    logic            wr_hit;
    logic [WAYS-1:0] hit_oh;
    logic [WAYS-1:0] vic_oh;

    // Tree stored heap-style in bits [WAYS-1:1]; bit 0 is never used. 0 = go to lower half.
    function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-1:0] t);
        logic [WAYW-1:0] node;
        logic [WAYW-1:0] way;
        node = WAYW'(1);
        way  = '0;
        for (int l = 0; l < WAYW; l++) begin
            way  = (way << 1) | WAYW'(t[node]);
            node = (node << 1) | WAYW'(t[node]);
        end
        return way;
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t,
                                                   input logic [WAYW-1:0] way);
        logic [WAYS-1:0] r;
        logic [WAYW-1:0] node;
        logic [WAYW-1:0] w;
        logic            b;
        r    = t;
        node = WAYW'(1);
        w    = way;
        for (int l = 0; l < WAYW; l++) begin
            b       = w[WAYW-1];
            r[node] = ~b;
            node    = (node << 1) | WAYW'(b);
            w       = w << 1;
        end
        return r;
    endfunction

    always_comb begin
        hit_sel = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (bus.hit_vec[i]) hit_sel = WAYW'(i);
        // An invalid way always beats the PLRU choice.
        miss_sel = plru_victim(plru[bus.set_idx]);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!bus.valid_vec[i]) miss_sel = WAYW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            victim_q  <= '0;
            hit_way   <= '0;
            hit_write <= 1'b0;
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        if (|bus.hit_vec) begin
                            hit_way   <= hit_sel;
                            hit_write <= bus.mem_write;
                            state     <= HIT;
                        end else begin
                            victim_q <= miss_sel;
                            state    <= bus.dirty_vec[miss_sel] ? WB : FILL;
                        end
                    end
                end
                HIT: begin
                    plru[bus.set_idx] <= plru_touch(plru[bus.set_idx], hit_way);
                    state             <= IDLE;
                end
                WB:      if (bus.pmem_resp) state <= FILL;
                FILL:    if (bus.pmem_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array enables are suppressed while rst is high so an aborted transaction writes nothing.
    always_comb begin
        fill_done = (state == FILL) && bus.pmem_resp && !rst;
        wr_hit    = (state == HIT) && hit_write && !rst;
        hit_oh    = WAYS'(1) << hit_way;
        vic_oh    = WAYS'(1) << victim_q;
    end

    assign bus.mem_resp      = (state == HIT) && !rst;
    assign bus.load_data     = wr_hit ? hit_oh : (fill_done ? vic_oh : '0);
    assign bus.load_dirty    = wr_hit ? hit_oh : (fill_done ? vic_oh : '0);
    assign bus.load_tag      = fill_done ? vic_oh : '0;
    assign bus.load_valid    = fill_done ? vic_oh : '0;
    assign bus.dirty_in      = wr_hit;
    assign bus.datain_sel    = fill_done;
    assign bus.pmem_addr_sel = (state == WB);
    assign bus.pmem_read     = (state == FILL);
    assign bus.pmem_write    = (state == WB);
    assign bus.victim_way    = victim_q;
endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: transaction-level reference model (recency-based PLRU) with per-cycle checks.
module tb_cache_control_nway;
    localparam int WAYS = 4;
    localparam int SETS = 8;
    localparam int IDXW = $clog2(SETS);
    localparam int WAYW = $clog2(WAYS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_control_nway_if #(.WAYS(WAYS), .SETS(SETS)) bus ();
    cache_control_nway #(.WAYS(WAYS), .SETS(SETS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned tick        = 0;
    int unsigned last_use [SETS][WAYS];

    logic            e_resp, e_din, e_dsel, e_asel, e_pr, e_pw;
    logic [WAYS-1:0] e_ld, e_lt, e_lv, e_ldt;
    int              e_vw;
    bit              e_vw_chk;

    // Tree PLRU equals: at each level descend into the half whose most recent access is older.
    function automatic int plru_pick(input int s);
        int          lo, sz, h;
        int unsigned ml, mr;
        lo = 0;
        sz = WAYS;
        while (sz > 1) begin
            h  = sz / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < h; i++) begin
                if (last_use[s][lo + i] > ml) ml = last_use[s][lo + i];
                if (last_use[s][lo + h + i] > mr) mr = last_use[s][lo + h + i];
            end
            if (ml > mr) lo = lo + h;
            sz = h;
        end
        return lo;
    endfunction

    function automatic int first_invalid(input logic [WAYS-1:0] vv);
        for (int i = 0; i < WAYS; i++)
            if (!vv[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) last_use[s][w] = 0;
    endtask

    task automatic clear_exp();
        e_resp = 0; e_din = 0; e_dsel = 0; e_asel = 0; e_pr = 0; e_pw = 0;
        e_ld = '0; e_lt = '0; e_lv = '0; e_ldt = '0; e_vw = 0; e_vw_chk = 0;
    endtask

    task automatic drive(input bit rd, input bit wr, input int s, input logic [WAYS-1:0] hv,
                         input logic [WAYS-1:0] vv, input logic [WAYS-1:0] dv);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.set_idx   = IDXW'(s);
        bus.hit_vec   = hv;
        bus.valid_vec = vv;
        bus.dirty_vec = dv;
    endtask

    task automatic check(input string nm);
        logic [4*WAYS+5:0] act, exp;
        act = {bus.mem_resp, bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty,
               bus.dirty_in, bus.datain_sel, bus.pmem_addr_sel, bus.pmem_read, bus.pmem_write};
        exp = {e_resp, e_ld, e_lt, e_lv, e_ldt, e_din, e_dsel, e_asel, e_pr, e_pw};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: outputs {resp,ld,lt,lv,ldirty,din,dsel,asel,pr,pw}=%h required %h",
                     nm, act, exp);
        end
        if (e_vw_chk) begin
            vectors++;
            if (bus.victim_way !== WAYW'(e_vw)) begin
                miscompares++;
                $display("FAIL %s_victim: victim_way=%0d required %0d", nm, bus.victim_way, e_vw);
            end
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step(input string nm);
        @(negedge clk);
        check(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, '0, '0, '0);
        bus.pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_exp();
        e_vw_chk = 1;
        e_vw = 0;
        step("reset_idle");
    endtask

    task automatic txn(input string nm, input bit rd, input bit wr, input int s,
                       input logic [WAYS-1:0] hv_in, input logic [WAYS-1:0] vv_in,
                       input logic [WAYS-1:0] dv_in, input int wb_lat, input int fill_lat,
                       output int vic, output int resp_cyc);
        logic [WAYS-1:0] hv, vv, dv, oh;
        int way, c;
        hv = hv_in; vv = vv_in; dv = dv_in; c = 0; vic = -1; way = 0;
        assert ($countones(hv) <= 1) else $error("%s: illegal multi-hit stimulus", nm);
        drive(rd, wr, s, hv, vv, dv);
        bus.pmem_resp = 1'($urandom_range(1));
        clear_exp();
        step({nm, "_req"}); c++;
        if (hv == '0) begin
            vic = first_invalid(vv);
            if (vic < 0) vic = plru_pick(s);
            oh = WAYS'(1) << vic;
            if (dv[vic]) begin
                for (int i = 0; i < wb_lat; i++) begin
                    clear_exp(); e_pw = 1; e_asel = 1; e_vw = vic; e_vw_chk = 1;
                    bus.pmem_resp = (i == wb_lat - 1);
                    step({nm, "_wb"}); c++;
                end
            end
            for (int i = 0; i < fill_lat; i++) begin
                clear_exp(); e_pr = 1; e_vw = vic; e_vw_chk = 1;
                bus.pmem_resp = (i == fill_lat - 1);
                if (i == fill_lat - 1) begin
                    e_ld = oh; e_lt = oh; e_lv = oh; e_ldt = oh; e_dsel = 1;
                end
                step({nm, "_fill"}); c++;
            end
            bus.pmem_resp = 1'b0;
            hv = oh; vv = vv | oh; dv = dv & ~oh;
            drive(rd, wr, s, hv, vv, dv);
            clear_exp();
            step({nm, "_refill_idle"}); c++;
            way = vic;
        end else begin
            for (int i = WAYS - 1; i >= 0; i--) if (hv[i]) way = i;
        end
        oh = WAYS'(1) << way;
        bus.pmem_resp = 1'($urandom_range(1));
        clear_exp(); e_resp = 1;
        if (wr) begin e_ld = oh; e_ldt = oh; e_din = 1; end
        resp_cyc = c;
        step({nm, "_hit"});
        tick++;
        last_use[s][way] = tick;
        bus.pmem_resp = 1'b0;
        drive(0, 0, s, hv, vv, dv);
        clear_exp();
        step({nm, "_done"});
    endtask

    task automatic mid_reset(input string nm, input int s, input logic [WAYS-1:0] vv,
                             input logic [WAYS-1:0] dv);
        drive(1, 0, s, '0, vv, dv);
        bus.pmem_resp = 1'b0;
        clear_exp();
        step({nm, "_req"});
        rst = 1'b1;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.mem_resp, bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty} !== '0) begin
            miscompares++;
            $display("FAIL %s_rst: enables=%h required 0", nm,
                     {bus.mem_resp, bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pmem_resp = 1'b0;
        drive(0, 0, s, '0, vv, dv);
        model_reset();
        clear_exp();
        e_vw_chk = 1;
        e_vw = 0;
        step({nm, "_after"});
    endtask

    initial begin
        int v, rc;
        model_reset();
        clear_exp();
        drive(0, 0, 0, '0, '0, '0);
        bus.pmem_resp = 1'b0;
        do_reset();

        txn("t1_read_hit", 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, v, rc);
        lit("t1_latency", rc, 1);
        txn("t1_plru", 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 1, 2, v, rc);
        lit("t1_plru_victim", v, 2);

        txn("t2_write_hit", 0, 1, 5, 4'b1000, 4'b1111, 4'b0000, 1, 1, v, rc);
        lit("t2_latency", rc, 1);
        txn("t2_rw_hit", 1, 1, 2, 4'b0001, 4'b0011, 4'b0001, 1, 1, v, rc);

        txn("t3_read_miss", 1, 0, 1, 4'b0000, 4'b1011, 4'b0000, 1, 6, v, rc);
        lit("t3_victim", v, 2);
        lit("t3_latency", rc, 8);

        txn("t4_dirty_miss", 0, 1, 3, 4'b0000, 4'b1111, 4'b1111, 3, 6, v, rc);
        lit("t4_victim", v, 0);
        lit("t4_latency", rc, 11);

        for (int w = 0; w < WAYS; w++)
            txn("t5_up", 1, 0, 4, WAYS'(1) << w, 4'b1111, 4'b0000, 1, 1, v, rc);
        txn("t5_up_miss", 1, 0, 4, 4'b0000, 4'b1111, 4'b0000, 1, 2, v, rc);
        lit("t5_up_victim", v, 0);
        for (int w = WAYS - 1; w >= 0; w--)
            txn("t5_down", 1, 0, 7, WAYS'(1) << w, 4'b1111, 4'b0000, 1, 1, v, rc);
        txn("t5_down_miss", 1, 0, 7, 4'b0000, 4'b1111, 4'b0000, 1, 2, v, rc);
        lit("t5_down_victim", v, 3);

        mid_reset("t6_wb", 2, 4'b1111, 4'b1111);
        mid_reset("t6_fill", 6, 4'b0111, 4'b0000);
        txn("t6_plru_cleared", 1, 0, 4, 4'b0000, 4'b1111, 4'b0000, 1, 1, v, rc);
        lit("t6_plru_victim", v, 0);

        for (int n = 0; n < 250; n++) begin
            int s, way, r, wl, fl;
            logic [WAYS-1:0] vv, dv, hv;
            bit rd, wr;
            s  = int'($urandom_range(SETS - 1));
            vv = WAYS'($urandom);
            if ($urandom_range(2) == 0) vv = '1;
            dv = WAYS'($urandom) & vv;
            r  = int'($urandom_range(2));
            rd = (r != 1);
            wr = (r != 0);
            hv = '0;
            if ($urandom_range(1) == 0) begin
                way = int'($urandom_range(WAYS - 1));
                hv  = WAYS'(1) << way;
                vv  = vv | hv;
            end
            wl = int'($urandom_range(4, 1));
            fl = int'($urandom_range(4, 1));
            txn("rand", rd, wr, s, hv, vv, dv, wl, fl, v, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
